// File: rtl/gamma_lut_multich_if.sv
// Host configuration bus for gamma_lut_multich: table writes, commit,
// bypass and status. With GAMMA_LUT_READBACK_EN defined it also carries
// the shadow-bank readback request/response signals.
interface gamma_lut_multich_if #(
    parameter int DW = 8,
    parameter int CW = 2
);
    logic          wr_valid;
    logic          wr_ready;
    logic [CW-1:0] wr_chan;
    logic [DW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic          bypass;
    logic          busy;
    logic          bank;
`ifdef GAMMA_LUT_READBACK_EN
    logic          rd_valid;
    logic [CW-1:0] rd_chan;
    logic [DW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_valid, wr_chan, wr_addr, wr_data, commit, bypass,
        output rd_valid, rd_chan, rd_addr,
        input  wr_ready, busy, bank, rd_ack, rd_data
    );
    modport slave (
        input  wr_valid, wr_chan, wr_addr, wr_data, commit, bypass,
        input  rd_valid, rd_chan, rd_addr,
        output wr_ready, busy, bank, rd_ack, rd_data
    );
`else
    modport master (
        output wr_valid, wr_chan, wr_addr, wr_data, commit, bypass,
        input  wr_ready, busy, bank
    );
    modport slave (
        input  wr_valid, wr_chan, wr_addr, wr_data, commit, bypass,
        output wr_ready, busy, bank
    );
`endif
endinterface

// File: rtl/gamma_lut_multich.sv
// Multi-channel, double-buffered gamma LUT with a fixed 2-cycle pipeline.
// Each channel owns a 2-bank table; the host fills the shadow bank and a
// commit swaps banks at the next frame start, so a frame never tears.
// Optional feature macro: GAMMA_LUT_READBACK_EN (shadow-bank readback).
module gamma_lut_multich #(
    parameter int DW     = 8,
    parameter int C      = 3,
    parameter int CW     = 2,
    parameter bit VS_POL = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [C*DW-1:0] i_pre_data,
    input  logic            i_pre_de,
    input  logic            i_pre_vsync,
    input  logic            i_pre_hsync,
    output logic [C*DW-1:0] o_post_data,
    output logic            o_post_de,
    output logic            o_post_vsync,
    output logic            o_post_hsync,
    gamma_lut_multich_if.slave cfg_if
);
    localparam int DEPTH = 2 ** (DW + 1);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_bank;
    logic            w_bank_next;
    logic            r_tbl_ok;
    logic            w_tbl_ok_next;
    logic            r_vs_d;
    logic            r_vs_vld;
    logic            w_frame_start;
    logic            w_wr_fire;

    logic [C*DW-1:0] r_s1_data;
    logic            r_s1_byp;
    logic            r_s1_de;
    logic            r_s1_vsync;
    logic            r_s1_hsync;
    logic [C*DW-1:0] w_lut_out;

    // Frame start is an edge into the active Vsync level. r_vs_vld masks the
    // first cycle after reset so a Vsync already active then is not an edge.
    assign w_frame_start = r_vs_vld && (i_pre_vsync == VS_POL) && (r_vs_d != VS_POL);
    assign w_wr_fire     = cfg_if.wr_valid && (r_state == ST_IDLE);

    assign cfg_if.busy     = (r_state == ST_PEND);
    assign cfg_if.wr_ready = (r_state == ST_IDLE);
    assign cfg_if.bank     = r_bank;

    // Vsync history for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_d   <= 1'b0;
            r_vs_vld <= 1'b0;
        end else begin
            r_vs_d   <= i_pre_vsync;
            r_vs_vld <= 1'b1;
        end
    end

    // Commit FSM state, active bank and table-valid flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_bank   <= 1'b0;
            r_tbl_ok <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bank   <= w_bank_next;
            r_tbl_ok <= w_tbl_ok_next;
        end
    end

    // Commit FSM next state: swap only from PEND, so a commit coinciding
    // with a frame start waits for the following one
    always_comb begin
        w_state_next  = r_state;
        w_bank_next   = r_bank;
        w_tbl_ok_next = r_tbl_ok;
        case (r_state)
            ST_IDLE: begin
                if (cfg_if.commit) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_frame_start) begin
                    w_state_next  = ST_IDLE;
                    w_bank_next   = ~r_bank;
                    w_tbl_ok_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef GAMMA_LUT_READBACK_EN
    logic          w_rd_fire;
    logic          r_rd_pend;
    logic [CW-1:0] r_rd_chan;
    logic          r_rd_ack;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] w_qb_all [C];
    logic [DW-1:0] w_rd_sel;

    // Reads never collide with a write request and are refused while the
    // shadow bank is frozen for a pending swap
    assign w_rd_fire      = cfg_if.rd_valid && !cfg_if.wr_valid && (r_state == ST_IDLE);
    assign cfg_if.rd_ack  = r_rd_ack;
    assign cfg_if.rd_data = r_rd_data;
`endif

    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_ch
            logic [DW-1:0] r_mem [0:DEPTH-1];
            logic [DW-1:0] r_qa;
            logic          w_we;

            assign w_we = w_wr_fire && (cfg_if.wr_chan == CW'(gi));
            assign w_lut_out[gi*DW +: DW] = r_qa;

            // Port A: pixel lookup in the active bank (registered read)
            always_ff @(posedge i_clk) begin
                r_qa <= r_mem[{r_bank, i_pre_data[gi*DW +: DW]}];
            end

`ifdef GAMMA_LUT_READBACK_EN
            logic [DW-1:0] r_qb;
            logic [DW-1:0] w_addr_b;

            assign w_addr_b     = w_wr_fire ? cfg_if.wr_addr : cfg_if.rd_addr;
            assign w_qb_all[gi] = r_qb;

            // Port B: host write or readback on the shadow bank
            always_ff @(posedge i_clk) begin
                if (w_we) begin
                    r_mem[{~r_bank, w_addr_b}] <= cfg_if.wr_data;
                end
                r_qb <= r_mem[{~r_bank, w_addr_b}];
            end
`else
            // Port B: host write into the shadow bank
            always_ff @(posedge i_clk) begin
                if (w_we) begin
                    r_mem[{~r_bank, cfg_if.wr_addr}] <= cfg_if.wr_data;
                end
            end
`endif
        end
    endgenerate

`ifdef GAMMA_LUT_READBACK_EN
    // Select the addressed channel's port-B data; channels >= C read as 0
    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < C; k++) begin
            if (r_rd_chan == CW'(k)) begin
                w_rd_sel = w_qb_all[k];
            end
        end
    end

    // Readback response two cycles after an accepted request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_pend <= 1'b0;
            r_rd_chan <= '0;
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_pend <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_chan <= cfg_if.rd_chan;
            end
            r_rd_ack <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= w_rd_sel;
            end
        end
    end
`endif

    // S1: capture pixel, timing and the bypass decision alongside the RAM read
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_data  <= '0;
            r_s1_byp   <= 1'b1;
            r_s1_de    <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_s1_hsync <= 1'b0;
        end else begin
            r_s1_data  <= i_pre_data;
            r_s1_byp   <= cfg_if.bypass || !r_tbl_ok;
            r_s1_de    <= i_pre_de;
            r_s1_vsync <= i_pre_vsync;
            r_s1_hsync <= i_pre_hsync;
        end
    end

    // S2: choose LUT result or delayed pixel; DE is carried, never used to gate
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_post_data  <= '0;
            o_post_de    <= 1'b0;
            o_post_vsync <= 1'b0;
            o_post_hsync <= 1'b0;
        end else begin
            o_post_data  <= r_s1_byp ? r_s1_data : w_lut_out;
            o_post_de    <= r_s1_de;
            o_post_vsync <= r_s1_vsync;
            o_post_hsync <= r_s1_hsync;
        end
    end
endmodule
